// File: rtl/apu_pkg.sv
// Shared APU definitions: frequency limit, sweep FSM encoding, sweep-period reload.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package apu_pkg;

  // Largest frequency the 11-bit channel counter can hold.
  localparam logic [10:0] FREQ_MAX = 11'h7FF;

  // A period field of 0 behaves as a period of 8. The 3-bit timer wraps 0 -> 7
  // on its first decrement, so 8 is stored as 0.
  localparam logic [2:0] PERIOD_ENC_8 = 3'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2,
    RECHK  = 2'd3
  } sweep_state_e;

  // Timer reload value for a given NR10 period field.
  function automatic logic [2:0] period_reload(input logic [2:0] period);
    return (period == 3'd0) ? PERIOD_ENC_8 : period;
  endfunction

endpackage

// File: rtl/ch1_sweep_calc.sv
// Sweep arithmetic: shadow +/- (shadow >> shift), with overflow flag past FREQ_MAX.
// Latency: purely combinational.
// Backpressure: none; the result is valid whenever the inputs are.
module ch1_sweep_calc
  import apu_pkg::*;
#(
  parameter int FREQ_W  = 11,
  parameter int SHIFT_W = 3
) (
  input  logic [FREQ_W-1:0]  shadow_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               negate_i,
  output logic [FREQ_W-1:0]  new_freq_o,
  output logic               overflow_o
);

  logic [FREQ_W:0] delta;
  logic [FREQ_W:0] sum;

  // One extra bit catches carry-out on add. Subtract cannot underflow,
  // because the shifted value never exceeds the shadow itself.
  always_comb begin
    delta      = {1'b0, shadow_i >> shift_i};
    sum        = negate_i ? ({1'b0, shadow_i} - delta) : ({1'b0, shadow_i} + delta);
    new_freq_o = sum[FREQ_W-1:0];
    overflow_o = !negate_i && (sum > {1'b0, FREQ_MAX});
  end

endmodule

// File: rtl/ch1_sweep_ctrl.sv
// Channel-1 frequency sweep sequencer: shadow register, sweep timer, load/disable strobes.
// Latency: tick -> CALC -> COMMIT, then freq_load is registered; recheck disable follows 1 cycle later.
// Backpressure: none; ticks that arrive while a sequence is in flight are dropped.
module ch1_sweep_ctrl
  import apu_pkg::*;
#(
  parameter int FREQ_W   = 11,
  parameter int PERIOD_W = 3,
  parameter int SHIFT_W  = 3
) (
  input  logic                dyfa_1mhz,
  input  logic                napu_reset,
  input  logic                sweep_tick,
  input  logic                ch1_restart,
  input  logic [PERIOD_W-1:0] sweep_period,
  input  logic                sweep_negate,
  input  logic [SHIFT_W-1:0]  sweep_shift,
  input  logic [FREQ_W-1:0]   freq_in,
  output logic [FREQ_W-1:0]   freq_out,
  output logic                freq_load,
  output logic                ch1_disable,
  output logic                sweep_busy
);

  sweep_state_e        state_q, state_d;
  logic [FREQ_W-1:0]   shadow_q, shadow_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic                sweep_en_q, sweep_en_d;
  logic                neg_used_q, neg_used_d;
  logic                negate_q;
  logic [FREQ_W-1:0]   freq_out_q, freq_out_d;
  logic                freq_load_q, freq_load_d;
  logic                disable_q, disable_d;

  logic [FREQ_W-1:0]   calc_freq;
  logic                calc_ovf;

  // One shared calculator; CALC, COMMIT and RECHK all evaluate the current shadow
  // with the live NR10 fields.
  ch1_sweep_calc #(
    .FREQ_W  (FREQ_W),
    .SHIFT_W (SHIFT_W)
  ) u_calc (
    .shadow_i   (shadow_q),
    .shift_i    (sweep_shift),
    .negate_i   (sweep_negate),
    .new_freq_o (calc_freq),
    .overflow_o (calc_ovf)
  );

  // Next-state logic: a trigger overrides everything, then the FSM step, then the negate quirk.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    timer_d     = timer_q;
    sweep_en_d  = sweep_en_q;
    neg_used_d  = neg_used_q;
    freq_out_d  = freq_out_q;
    freq_load_d = 1'b0;
    disable_d   = 1'b0;

    if (ch1_restart) begin
      shadow_d   = freq_in;
      timer_d    = period_reload(sweep_period);
      neg_used_d = 1'b0;
      sweep_en_d = (sweep_period != '0) || (sweep_shift != '0);
      state_d    = (sweep_shift != '0) ? RECHK : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sweep_tick) begin
            // Timer value 0 stands for 8, so it still counts down (0 -> 7).
            if (timer_q != PERIOD_W'(1)) begin
              timer_d = timer_q - PERIOD_W'(1);
            end else begin
              timer_d = period_reload(sweep_period);
              if (sweep_en_q && (sweep_period != '0)) begin
                state_d = CALC;
              end
            end
          end
        end
        CALC: begin
          if (sweep_negate) neg_used_d = 1'b1;
          if (calc_ovf) begin
            disable_d  = 1'b1;
            sweep_en_d = 1'b0;
            state_d    = IDLE;
          end else if (sweep_shift != '0) begin
            state_d = COMMIT;
          end else begin
            state_d = IDLE;
          end
        end
        COMMIT: begin
          shadow_d    = calc_freq;
          freq_out_d  = calc_freq;
          freq_load_d = 1'b1;
          state_d     = RECHK;
        end
        RECHK: begin
          if (sweep_negate) neg_used_d = 1'b1;
          if (calc_ovf) begin
            disable_d  = 1'b1;
            sweep_en_d = 1'b0;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // Leaving subtract mode after a subtract was used kills the channel.
      if (negate_q && !sweep_negate && neg_used_q && sweep_en_q) begin
        disable_d  = 1'b1;
        sweep_en_d = 1'b0;
      end
    end
  end

  // State and strobe registers; async reset clears everything without emitting a strobe.
  always_ff @(posedge dyfa_1mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      timer_q     <= '0;
      sweep_en_q  <= 1'b0;
      neg_used_q  <= 1'b0;
      negate_q    <= 1'b0;
      freq_out_q  <= '0;
      freq_load_q <= 1'b0;
      disable_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      timer_q     <= timer_d;
      sweep_en_q  <= sweep_en_d;
      neg_used_q  <= neg_used_d;
      negate_q    <= sweep_negate;
      freq_out_q  <= freq_out_d;
      freq_load_q <= freq_load_d;
      disable_q   <= disable_d;
    end
  end

  assign freq_out    = freq_out_q;
  assign freq_load   = freq_load_q;
  assign ch1_disable = disable_q;
  assign sweep_busy  = (state_q != IDLE);

endmodule

// File: doc/ch1_sweep_ctrl.md
Name: ch1_sweep_ctrl

Overview:
Frequency-sweep sequencer for sound channel 1. It uses the NR10 sweep fields and the 11-bit NR13/NR14 frequency. It keeps a shadow frequency and steps it up or down at the sweep rate, and reloads the channel-1 frequency counter with each new value. It also raises a channel-disable strobe when the frequency overflows 2047. It sits between the ch1 register block and the ch1 frequency counter, driving that counter's load data and load enable.

Parameters:
FREQ_W, 11, width of frequency / shadow register
PERIOD_W, 3, width of NR10 sweep period field
SHIFT_W, 3, width of NR10 sweep shift field

Ports:
dyfa_1mhz  in  1  APU clock; all state changes on rising edge
napu_reset  in  1  asynchronous active-low reset
sweep_tick  in  1  one-cycle 128 Hz frame-sequencer strobe
ch1_restart  in  1  one-cycle trigger strobe (NR14 bit 7 write)
sweep_period  in  3  NR10[6:4], true polarity
sweep_negate  in  1  NR10[3], 1 = subtract
sweep_shift  in  3  NR10[2:0]
freq_in  in  11  current NR14[2:0]:NR13 value
freq_out  out  11  new frequency, drives counter acc_d
freq_load  out  1  one-cycle strobe: load freq_out into counter and NR13/14
ch1_disable  out  1  one-cycle strobe: overflow/negate-quirk, stop channel
sweep_busy  out  1  high while FSM is not in IDLE

Behaviour:
- Reset state: every register is 0; FSM is in IDLE; all outputs are 0.
- State:
  - shadow[10:0]
  - timer[2:0]
  - sweep_en
  - neg_used (a subtract calculation has been performed since the last trigger)
  - FSM: IDLE, CALC, COMMIT, RECHK
- Calculation: new = shadow ± (shadow >> sweep_shift), computed 12 bits wide. Overflow means new > 2047, i.e. bit 11 set on an add. A subtract never overflows. Every subtract calculation sets neg_used.
- Trigger (ch1_restart in IDLE or any state; it aborts an in-flight sequence):
  - shadow <= freq_in.
  - timer <= period, or 8 (encoded 0) when period = 0.
  - neg_used <= 0.
  - sweep_en <= (period != 0) || (shift != 0).
  - If shift != 0, go to RECHK next cycle (overflow check only, no write).
- Tick, when not triggered in the same cycle:
  - If timer > 1, decrement timer.
  - Otherwise reload the timer (period, or 8). Then, if sweep_en && period != 0, go to CALC.
  - Ticks arriving while FSM is not IDLE are dropped.
- CALC (1 cycle):
  - Evaluate new.
  - If overflow: pulse ch1_disable, clear sweep_en, go to IDLE.
  - Else, if shift != 0, go to COMMIT; if shift == 0, go to IDLE with no write.
- COMMIT (1 cycle): shadow <= new; freq_out <= new[10:0]; pulse freq_load; go to RECHK.
- RECHK (1 cycle):
  - Evaluate new from the current shadow; write nothing.
  - If overflow: pulse ch1_disable and clear sweep_en.
  - Go to IDLE.
- Latency, from tick to freq_load: 2 cycles (tick edge → CALC → COMMIT). ch1_disable from the recheck follows freq_load by 1 cycle.
- Negate quirk: if sweep_negate goes 1→0 while neg_used = 1 and sweep_en = 1, pulse ch1_disable on the next cycle and clear sweep_en.
- Simultaneous events:
  - Trigger beats tick in the same cycle; the tick is dropped.
  - Trigger during CALC/COMMIT/RECHK abandons that sequence with no freq_load.
- Between sweeps, freq_in changes do not affect shadow; shadow changes only on trigger or COMMIT.
- NR10 fields are sampled live at each state, not latched.
- Async reset asserted mid-sequence forces reset values immediately; no strobe is emitted.
- freq_out holds its last value between loads.

Decomposition:
- Shared package apu_pkg:
  - FREQ_MAX = 11'h7FF.
  - Sweep FSM state enum: IDLE = 0, CALC = 1, COMMIT = 2, RECHK = 3.
  - Period encoding constant for 8.
- One natural sub-module, ch1_sweep_calc: combinational shift plus add/subtract with an overflow flag, reused by CALC and RECHK.

Test Plan:
1. Add overflow after one step:
   - Setup: freq_in = 0x400, period = 1, shift = 1, negate = 0; trigger; 1 tick.
   - Required: freq_load with freq_out = 0x600.
   - Next cycle: ch1_disable, because the recheck gives 0x900 > 2047.
2. Subtract sweep:
   - Setup: freq_in = 0x100, period = 2, shift = 2, negate = 1; trigger.
   - 1st tick: no load.
   - 2nd tick: freq_out = 0x0C0.
   - 2 more ticks: freq_out = 0x090.
   - ch1_disable never asserts.
3. Shift 0 still checks overflow:
   - Setup: freq_in = 0x500, period = 1, shift = 0; trigger; 1 tick.
   - Required: ch1_disable (0xA00), no freq_load.
   - With freq_in = 0x300, the same sequence gives no strobe at all.
4. Trigger-time check:
   - Setup: freq_in = 0x7F0, shift = 1, period = 0; trigger.
   - Required: ch1_disable 1 cycle later.
   - Later ticks produce nothing, because period = 0.
5. Negate quirk:
   - Scenario 2 after its first load, then clear sweep_negate → ch1_disable next cycle.
   - Same toggle before any calculation → no strobe.
6. Races and reset:
   - Trigger and tick in the same cycle → timer reloads, no CALC.
   - napu_reset low during COMMIT → freq_load stays 0; all outputs read 0.
